lcd_cmd_sequencer: RTL and testbench

Command scheduler in front of the LCD image-processing controller (8x8 image, 4x4 operation window, cmd/cmd_valid/busy/done interface). It buffers host commands in a FIFO and filters out illegal codes. It issues one command at a time to the controller, respecting the busy handshake and a post-reset load phase, and reports progress and errors. Sits between the host/testbench command source and the controller's cmd port.

---
 rtl/lcd_cmd_sequencer_if.sv | 15 +
 rtl/lcd_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// Host-side command handshake and controller-side issue/busy/done signals.
interface lcd_cmd_sequencer_if;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;

  modport master (output host_cmd, host_valid, lcd_busy, lcd_done,
                  input  host_ready, lcd_cmd, lcd_cmd_valid);
  modport slave  (input  host_cmd, host_valid, lcd_busy, lcd_done,
                  output host_ready, lcd_cmd, lcd_cmd_valid);
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands, drops illegal codes and issues them one at a time
// to the LCD controller, tracking busy/done, frames and ack timeouts.
module lcd_cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_cmd_sequencer_if.slave     bus,
  input  logic                   hold,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   frame_done,
  output logic                   err_illegal,
  output logic                   err_timeout,
  output logic                   seq_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LVL   = TW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          do_issue, do_timeout, do_frame;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, accept, push, pop;

  logic [3:0]    cmd_q;
  logic          cmd_vld_q;
  logic          is_write;

  // Only codes 0..7 are legal, so bit 3 alone marks an illegal push.
  assign full           = (count == FULL_LVL);
  assign empty          = (count == '0);
  assign bus.host_ready = !full && !flush;
  assign accept         = bus.host_valid && bus.host_ready;
  assign push           = accept && !bus.host_cmd[3];
  assign pop            = do_issue;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.host_cmd[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Timer counts cycles since the issue strobe, so the timeout lands
  // exactly ACK_TIMEOUT cycles after lcd_cmd_valid rose.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    do_issue   = 1'b0;
    do_timeout = 1'b0;
    do_frame   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !hold && !bus.lcd_busy) begin
          do_issue  = 1'b1;
          timer_nxt = '0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nxt = timer + TW'(1);
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.lcd_busy) begin
          state_nxt = S_WAIT_DONE;
        end else begin
          timer_nxt = timer + TW'(1);
          if (timer_nxt == TO_LVL) begin
            do_timeout = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!bus.lcd_busy && (!is_write || bus.lcd_done)) begin
          do_frame  = is_write;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      cmd_q       <= '0;
      cmd_vld_q   <= 1'b0;
      is_write    <= 1'b0;
      issued_cnt  <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      cmd_vld_q  <= do_issue;
      frame_done <= do_frame;
      if (do_issue) begin
        cmd_q      <= {1'b0, mem[rd_ptr]};
        is_write   <= (mem[rd_ptr] == 3'd0);
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      if (do_frame)                      frame_cnt   <= frame_cnt + CNT_W'(1);
      if (do_timeout)                    err_timeout <= 1'b1;
      if (accept && bus.host_cmd[3])     err_illegal <= 1'b1;
    end
  end

  assign bus.lcd_cmd       = cmd_q;
  assign bus.lcd_cmd_valid = cmd_vld_q;
  assign fifo_level        = count;
  assign seq_idle          = (state == S_IDLE) && empty;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench: host pushes and a hand-driven controller model around
// the sequencer, each check against a hand-computed value.
module tb_lcd_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] issued_cnt, frame_cnt;
  logic        frame_done, err_illegal, err_timeout, seq_idle;
  int          total = 0;
  int          bad = 0;
  logic        seen;
  logic [3:0]  codes [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd6, 4'd6};

  lcd_cmd_sequencer_if bus();

  lcd_cmd_sequencer #(.DEPTH(8), .ACK_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .hold(hold), .flush(flush),
    .fifo_level(fifo_level), .issued_cnt(issued_cnt), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .seq_idle(seq_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy);
    bus.lcd_busy = busy; bus.lcd_done = 1'b0;
    bus.host_valid = 1'b0; bus.host_cmd = 4'd0;
    hold = 1'b0; flush = 1'b0;
    rst = 1'b1; tick; tick;
    rst = 1'b0; tick;
  endtask

  task automatic push(input logic [3:0] c);
    bus.host_cmd = c; bus.host_valid = 1'b1;
    tick;
    bus.host_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      found = bus.lcd_cmd_valid;
    end
    chk(tag, found, 1);
  endtask

  task automatic idle_check(input string tag, input int n);
    int v = 0;
    repeat (n) begin tick; v += int'(bus.lcd_cmd_valid); end
    chk(tag, v, 0);
  endtask

  // Controller model: ack by raising busy, hold it, then drop busy (plus done for WRITE).
  task automatic serve(input string tag, input logic [3:0] c, input int busy_cyc,
                       input logic wr, input int done_dly);
    logic f;
    wait_issue({tag, "_issue"}, f);
    if (!f) return;
    chk({tag, "_cmd"}, bus.lcd_cmd, c);
    bus.lcd_busy = 1'b1;
    tick;
    chk({tag, "_strobe"}, bus.lcd_cmd_valid, 0);
    repeat (busy_cyc) tick;
    bus.lcd_busy = 1'b0;
    if (wr) begin
      repeat (done_dly) begin tick; chk({tag, "_nodone"}, frame_done, 0); end
      bus.lcd_done = 1'b1;
      tick;
      chk({tag, "_frame"}, frame_done, 1);
      bus.lcd_done = 1'b0;
      tick;
      chk({tag, "_pulse"}, frame_done, 0);
    end else begin
      tick;
    end
  endtask

  initial begin
    bus.lcd_busy = 1'b1; bus.lcd_done = 1'b0;
    bus.host_valid = 1'b0; bus.host_cmd = 4'd0;
    rst = 1'b1;
    tick;
    chk("rst_valid", bus.lcd_cmd_valid, 0);
    chk("rst_cmd", bus.lcd_cmd, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_errs", {err_illegal, err_timeout}, 0);
    chk("rst_idle", seq_idle, 1);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;
    tick;
    chk("rst_ready", bus.host_ready, 1);

    // 1: controller load phase holds off issue
    push(4'd1); push(4'd5);
    idle_check("t1_busy_hold", 60);
    chk("t1_level", fifo_level, 2);
    bus.lcd_busy = 1'b0;
    serve("t1a", 4'd1, 3, 1'b0, 0);
    serve("t1b", 4'd5, 3, 1'b0, 0);
    chk("t1_issued", issued_cnt, 2);
    chk("t1_idle", seq_idle, 1);

    // 2: WRITE frame completion, immediate and delayed done
    do_reset(1'b0);
    push(4'd0);
    serve("t2a", 4'd0, 65, 1'b1, 0);
    chk("t2_frame1", frame_cnt, 1);
    chk("t2_idle", seq_idle, 1);
    push(4'd0);
    serve("t2b", 4'd0, 4, 1'b1, 3);
    chk("t2_frame2", frame_cnt, 2);

    // 3: fill past DEPTH, then drain in order
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push(codes[i]);
    chk("t3_full_ready", bus.host_ready, 0);
    chk("t3_full_level", fifo_level, 8);
    push(codes[8]); push(codes[9]);
    chk("t3_reject_level", fifo_level, 8);
    bus.lcd_busy = 1'b0;
    for (int i = 0; i < 8; i++) serve($sformatf("t3_%0d", i), codes[i], 2, 1'b0, 0);
    chk("t3_issued", issued_cnt, 8);
    chk("t3_empty", fifo_level, 0);

    // 4: illegal code filtered, no bypass on empty FIFO
    do_reset(1'b0);
    push(4'd12);
    chk("t4_err", err_illegal, 1);
    chk("t4_level0", fifo_level, 0);
    push(4'd3);
    chk("t4_nobypass", bus.lcd_cmd_valid, 0);
    chk("t4_level1", fifo_level, 1);
    serve("t4", 4'd3, 2, 1'b0, 0);
    chk("t4_issued", issued_cnt, 1);
    idle_check("t4_only_one", 10);

    // 5: ack timeout then normal issue
    do_reset(1'b0);
    hold = 1'b1;
    push(4'd7); push(4'd2);
    hold = 1'b0;
    wait_issue("t5_issue", seen);
    chk("t5_cmd", bus.lcd_cmd, 7);
    repeat (15) tick;
    chk("t5_early", err_timeout, 0);
    tick;
    chk("t5_timeout", err_timeout, 1);
    serve("t5b", 4'd2, 3, 1'b0, 0);
    chk("t5_issued", issued_cnt, 2);
    chk("t5_sticky", err_timeout, 1);

    // reset in the middle of a command
    push(4'd4);
    wait_issue("t7_issue", seen);
    rst = 1'b1;
    #1;
    chk("t7_valid", bus.lcd_cmd_valid, 0);
    chk("t7_issued", issued_cnt, 0);
    chk("t7_errclr", err_timeout, 0);
    chk("t7_idle", seq_idle, 1);
    rst = 1'b0;
    tick;

    // 6: hold then flush with a colliding push
    do_reset(1'b0);
    hold = 1'b1;
    push(4'd1); push(4'd2); push(4'd3);
    idle_check("t6_hold", 10);
    chk("t6_level3", fifo_level, 3);
    flush = 1'b1; bus.host_cmd = 4'd4; bus.host_valid = 1'b1;
    #1;
    chk("t6_flush_ready", bus.host_ready, 0);
    tick;
    flush = 1'b0; bus.host_valid = 1'b0;
    chk("t6_flushed", fifo_level, 0);
    hold = 1'b0;
    idle_check("t6_no_issue", 10);
    chk("t6_idle", seq_idle, 1);
    chk("t6_issued", issued_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
